// File: rtl/debug_dump_tx_pkg.sv
// Shared debug definitions: dump FSM states, frame header and the byte layout of a dump frame.
package debug_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum int {
    F_PC, F_REGS, F_IF_ID, F_ID_EX, F_EX_MEM, F_MEM_WB, F_MEM, F_CSUM
  } field_t;

  localparam logic [7:0] HEADER = 8'hA5;

  function automatic int bytes_of(input int bits);
    return (bits + 7) / 8;
  endfunction

  // Byte offset of a field in the frame; fields follow the header in enum order.
  function automatic int field_off(input field_t f, input int size, input int nreg,
                                   input int msize, input int ifid, input int idex,
                                   input int exmem, input int memwb);
    int off;
    off = 1;
    if (f > F_PC)     off += bytes_of(size);
    if (f > F_REGS)   off += nreg * bytes_of(size);
    if (f > F_IF_ID)  off += bytes_of(ifid);
    if (f > F_ID_EX)  off += bytes_of(idex);
    if (f > F_EX_MEM) off += bytes_of(exmem);
    if (f > F_MEM_WB) off += bytes_of(memwb);
    if (f > F_MEM)    off += msize * bytes_of(size);
    return off;
  endfunction

  localparam int DEF_FRAME_LEN = field_off(F_CSUM, 32, 32, 64, 64, 129, 78, 72) + 1;

endpackage

// File: rtl/debug_dump_tx_byte_sel.sv
// Maps a frame byte index to the outgoing byte; also flags the first byte of each memory word.
module dump_byte_sel
  import debug_dump_tx_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int MEM_SIZE      = 64,
  parameter int IF_ID_SIZE    = 64,
  parameter int ID_EX_SIZE    = 129,
  parameter int EX_MEM_SIZE   = 78,
  parameter int MEM_WB_SIZE   = 72,
  parameter int CW            = 9
) (
  input  logic [CW-1:0]               idx,
  input  logic [SIZE-1:0]             pc,
  input  logic [NUM_REGISTERS*SIZE-1:0] registers,
  input  logic [IF_ID_SIZE-1:0]       if_id,
  input  logic [ID_EX_SIZE-1:0]       id_ex,
  input  logic [EX_MEM_SIZE-1:0]      ex_mem,
  input  logic [MEM_WB_SIZE-1:0]      mem_wb,
  input  logic [SIZE-1:0]             mem_hold,
  input  logic [7:0]                  csum,
  output logic [7:0]                  tx_byte,
  output logic                        mem_first,
  output logic [$clog2(MEM_SIZE)-1:0] mem_word
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int WB = bytes_of(SIZE);
  localparam int PC_OFF     = field_off(F_PC, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int REG_OFF    = field_off(F_REGS, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int IF_ID_OFF  = field_off(F_IF_ID, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int ID_EX_OFF  = field_off(F_ID_EX, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int EX_MEM_OFF = field_off(F_EX_MEM, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int MEM_WB_OFF = field_off(F_MEM_WB, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int MEM_OFF    = field_off(F_MEM, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);
  localparam int CSUM_OFF   = field_off(F_CSUM, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE, ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE);

  int i;
  int b;

  // Shifting the narrow field right and truncating to 8 bits zero-fills a field's last byte.
  always_comb begin
    i         = int'(idx);
    b         = 0;
    tx_byte   = 8'h00;
    mem_first = 1'b0;
    mem_word  = '0;
    if (i == 0) begin
      tx_byte = HEADER;
    end else if (i < REG_OFF) begin
      tx_byte = 8'(pc >> (8 * (i - PC_OFF)));
    end else if (i < IF_ID_OFF) begin
      b       = i - REG_OFF;
      tx_byte = 8'(SIZE'(registers >> (SIZE * (b / WB))) >> (8 * (b % WB)));
    end else if (i < ID_EX_OFF) begin
      tx_byte = 8'(if_id >> (8 * (i - IF_ID_OFF)));
    end else if (i < EX_MEM_OFF) begin
      tx_byte = 8'(id_ex >> (8 * (i - ID_EX_OFF)));
    end else if (i < MEM_WB_OFF) begin
      tx_byte = 8'(ex_mem >> (8 * (i - EX_MEM_OFF)));
    end else if (i < MEM_OFF) begin
      tx_byte = 8'(mem_wb >> (8 * (i - MEM_WB_OFF)));
    end else if (i < CSUM_OFF) begin
      b         = i - MEM_OFF;
      tx_byte   = 8'(mem_hold >> (8 * (b % WB)));
      mem_first = (b % WB) == 0;
      mem_word  = AW'(b / WB);
    end else begin
      tx_byte = csum;
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Streams one debug dump frame (header, PC, registers, pipeline latches, data memory, checksum)
// to a byte UART, one byte per i_tx_done handshake.
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int MEM_SIZE      = 64,
  parameter int IF_ID_SIZE    = 64,
  parameter int ID_EX_SIZE    = 129,
  parameter int EX_MEM_SIZE   = 78,
  parameter int MEM_WB_SIZE   = 72
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [SIZE-1:0]               i_pc,
  input  logic [NUM_REGISTERS*SIZE-1:0] i_registers,
  input  logic [IF_ID_SIZE-1:0]         i_if_id,
  input  logic [ID_EX_SIZE-1:0]         i_id_ex,
  input  logic [EX_MEM_SIZE-1:0]        i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0]        i_mem_wb,
  output logic [$clog2(MEM_SIZE)-1:0]   o_mem_addr,
  input  logic [SIZE-1:0]               i_mem_data,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int FRAME_LEN = field_off(F_CSUM, SIZE, NUM_REGISTERS, MEM_SIZE, IF_ID_SIZE,
                                       ID_EX_SIZE, EX_MEM_SIZE, MEM_WB_SIZE) + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] END_IDX  = CW'(FRAME_LEN);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      csum_q;
  logic [7:0]      sel_byte;
  logic [SIZE-1:0] hold_q;
  logic [AW-1:0]   mem_addr_q;
  logic [AW-1:0]   mem_word;
  logic            fetch_ph_q;
  logic            mem_first;

  dump_byte_sel #(
    .SIZE(SIZE), .NUM_REGISTERS(NUM_REGISTERS), .MEM_SIZE(MEM_SIZE),
    .IF_ID_SIZE(IF_ID_SIZE), .ID_EX_SIZE(ID_EX_SIZE), .EX_MEM_SIZE(EX_MEM_SIZE),
    .MEM_WB_SIZE(MEM_WB_SIZE), .CW(CW)
  ) u_sel (
    .idx(cnt_q), .pc(i_pc), .registers(i_registers), .if_id(i_if_id), .id_ex(i_id_ex),
    .ex_mem(i_ex_mem), .mem_wb(i_mem_wb), .mem_hold(hold_q), .csum(csum_q),
    .tx_byte(sel_byte), .mem_first(mem_first), .mem_word(mem_word)
  );

  // In WAIT the counter already points at the next byte, so the decode drives the branch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (i_start) state_d = SEND;
      SEND:  state_d = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (cnt_q == END_IDX) state_d = DONE;
          else if (mem_first)   state_d = FETCH;
          else                  state_d = SEND;
        end
      end
      FETCH: if (fetch_ph_q) state_d = SEND;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      csum_q     <= '0;
      hold_q     <= '0;
      mem_addr_q <= '0;
      fetch_ph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            cnt_q  <= '0;
            csum_q <= '0;
          end
        end
        SEND: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q != '0 && cnt_q != LAST_IDX) csum_q <= csum_q ^ sel_byte;
        end
        WAIT: begin
          if (state_d == FETCH) begin
            mem_addr_q <= mem_word;
            fetch_ph_q <= 1'b0;
          end
        end
        // First FETCH cycle covers the memory's one-cycle read latency.
        FETCH: begin
          fetch_ph_q <= 1'b1;
          if (fetch_ph_q) hold_q <= i_mem_data;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr = mem_addr_q;
  assign o_tx_start = (state_q == SEND);
  assign o_tx_data  = (state_q == SEND) ? sel_byte : 8'h00;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);

endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface — parameters
REQ-001 SHALL have parameter SIZE, default 32, data/register word width in bits.
REQ-002 SHALL have parameter NUM_REGISTERS, default 32, number of register-file words dumped.
REQ-003 SHALL have parameter MEM_SIZE, default 64, number of data-memory words dumped.
REQ-004 SHALL have parameters IF_ID_SIZE 64, ID_EX_SIZE 129, EX_MEM_SIZE 78, MEM_WB_SIZE 72, the pipeline-latch widths in bits.

Interface — ports
REQ-005 SHALL have these ports, one per line, as name, direction, width, meaning:
- i_clk, in, 1, single clock; all logic on its rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, one-cycle request to send one dump frame.
- i_pc, in, SIZE, program counter.
- i_registers, in, NUM_REGISTERS*SIZE, flattened register file; register k sits at bits [k*SIZE +: SIZE].
- i_if_id, i_id_ex, i_ex_mem, i_mem_wb, in, the *_SIZE widths, pipeline latch contents.
- o_mem_addr, out, clog2(MEM_SIZE), data-memory debug read address.
- i_mem_data, in, SIZE, data-memory word, valid one cycle after o_mem_addr changes.
- o_tx_data, out, 8, byte to the UART transmitter.
- o_tx_start, out, 1, one-cycle pulse that launches o_tx_data.
- i_tx_done, in, 1, one-cycle tick when the UART has finished a byte.
- o_busy, out, 1, high while a frame is in progress.
- o_done, out, 1, one-cycle pulse after the last byte's i_tx_done.

Function
REQ-006 Frame byte order SHALL be:
- header 0xA5;
- PC, 4 bytes;
- registers 0..NUM_REGISTERS-1, 4 bytes each;
- IF_ID, ceil(64/8)=8 bytes; ID_EX, 17 bytes; EX_MEM, 10 bytes; MEM_WB, 9 bytes;
- memory words 0..MEM_SIZE-1, 4 bytes each;
- checksum, 1 byte.
REQ-007 Every multi-byte field SHALL be sent least-significant byte first; unused bits in a field's last byte SHALL be zero.
REQ-008 With default parameters the frame SHALL be 434 bytes long.
REQ-009 The checksum SHALL be the XOR of every byte after the header and before the checksum itself.
REQ-010 The FSM SHALL have states IDLE, FETCH, SEND, WAIT, DONE.
REQ-011 IDLE: i_start SHALL clear the byte counter and the checksum and move to SEND.
REQ-012 SEND SHALL hold o_tx_start and o_tx_data for exactly one cycle, fold the byte into the checksum, then move to WAIT.
REQ-013 WAIT SHALL advance on i_tx_done:
- next byte is a memory word's byte 0 -> FETCH;
- bytes remain -> SEND;
- last byte sent -> DONE.
REQ-014 FETCH SHALL drive o_mem_addr with the word index, wait one cycle, capture i_mem_data into a SIZE-bit hold register, then move to SEND; memory bytes 1..3 SHALL come from that hold register.
REQ-015 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-016 o_busy SHALL be high in every state except IDLE.
REQ-017 Non-memory fields SHALL be read combinationally from the inputs, which the debugger holds stable for the whole frame (pipeline clock gated).
REQ-018 i_start SHALL be ignored when not in IDLE.
REQ-019 i_tx_done SHALL be ignored outside WAIT.
REQ-020 i_start and i_tx_done in the same IDLE cycle SHALL start a frame and discard the tick.
REQ-021 The byte counter SHALL be wide enough for the frame length and SHALL NOT wrap within a frame.
REQ-022 Latency from i_start to the first o_tx_start SHALL be exactly 1 cycle.
REQ-023 From each i_tx_done to the next o_tx_start SHALL be 1 cycle, or 3 cycles when FETCH runs.

Reset
REQ-024 On i_rst_n low, asynchronously: state IDLE; counter, checksum, hold register, o_mem_addr, o_tx_data zero; o_tx_start, o_busy, o_done low.
REQ-025 Reset mid-frame SHALL abort the frame with no further o_tx_start; the next frame after reset SHALL start from the header.

Structure
REQ-026 State encodings, the header value 0xA5 and the per-field byte counts/offsets SHALL live in the shared debug package, also used by the debugger.
REQ-027 A single sub-module, dump_byte_sel, SHALL map the byte index to the outgoing byte combinationally; the FSM stays in debug_dump_tx.

Verification
REQ-028 Start with PC=0x00000010, r1=0x11223344, all other inputs zero, auto-ack i_tx_done 5 cycles after each start:
- 434 bytes;
- byte0=0xA5;
- bytes1-4=10 00 00 00;
- bytes9-12=44 33 22 11;
- checksum=0x10^0x44^0x33^0x22^0x11=0x54.
REQ-029 ID_EX all ones -> 16 bytes 0xFF, then 0x01 (upper 7 bits zero).
REQ-030 Memory word 63=0xDEADBEEF -> bytes 429-432 = EF BE AD DE; o_mem_addr=63 during that FETCH.
REQ-031 i_start pulsed again at byte 50 and i_tx_done pulsed in IDLE -> no effect; exactly one o_done after 434 bytes.
REQ-032 i_rst_n low during byte 200 -> o_busy drops at once, no o_tx_start; a new i_start yields header 0xA5 first.
REQ-033 Back-to-back frames (i_start the cycle after o_done) -> two identical 434-byte frames with equal checksums.
